rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the in-order WB stage (pipe) and a long-latency unit (LL: load miss / mul-div).
- Keeps a 31-bit busy scoreboard of registers owned by in-flight LL ops and raises a RAW/WAW stall to ID.
- Prevents LL starvation by briefly holding the pipeline.
- Sits between WB/LL and the register file; drives the file's write enable, rd and data.

---
 rtl/rv_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and widths for the register-file write-back slice.
// Holds the arbiter state encoding and datapath widths.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_FORCE
  } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for registers owned by in-flight long-latency ops.
// x0 is never busy; a same-cycle set and clear of one register keeps it busy.
module rf_scoreboard
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  hit
);

  logic [31:1] busy_q;
  logic [31:1] busy_d;
  logic [31:1] set_mask;
  logic [31:1] clr_mask;
  logic [31:0] busy;

  // decode set/clear masks; set is applied after clear so it wins
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < 32; i++) begin
      set_mask[i] = set_en && (set_rd == REG_ADDR_W'(i));
      clr_mask[i] = clr_en && (clr_rd == REG_ADDR_W'(i));
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // busy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // hazard lookup for the instruction sitting in ID
  always_comb begin
    busy = {busy_q, 1'b0};
    hit  = busy[rs1] | busy[rs2] | busy[rd];
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between WB and the long-latency unit.
// Optional RF_WB_PERF_CNT_EN adds a saturating conflict counter output.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = rv_pkg::XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pipe_wr_en_i,
  input  logic [REG_ADDR_W-1:0] pipe_rd_i,
  input  logic [XLEN-1:0]       pipe_wr_data_i,
  input  logic                  ll_valid_i,
  input  logic [REG_ADDR_W-1:0] ll_rd_i,
  input  logic [XLEN-1:0]       ll_data_i,
  output logic                  ll_ready_o,
  input  logic                  issue_en_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  output logic                  raw_stall_o,
  output logic                  pipe_hold_o,
  output logic                  rf_wr_en_o,
  output logic [REG_ADDR_W-1:0] rf_rd_o,
  output logic [XLEN-1:0]       rf_wr_data_o
`ifdef RF_WB_PERF_CNT_EN
  ,
  output logic [31:0]           conflict_cnt_o
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW:0] MAXW = (CW+1)'(MAX_WAIT);

  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   refused;
  logic          port_busy;
  logic          xfer;
  logic          wr_en_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic [XLEN-1:0]       data_d;

  // port ownership and LL grant; a WB write in FORCE still wins,
  // so the LL result is refused rather than dropped
  always_comb begin
    port_busy  = pipe_wr_en_i && (pipe_rd_i != '0);
    ll_ready_o = ll_valid_i && !port_busy;
    xfer       = ll_valid_i && ll_ready_o;
  end

  // next state; refused counts refusals including this cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    refused = (state_q == ARB_IDLE) ? (CW+1)'(1)
                                    : {1'b0, cnt_q} + (CW+1)'(1);
    unique case (state_q)
      ARB_IDLE: begin
        if (ll_valid_i && !ll_ready_o) begin
          cnt_d   = CW'(1);
          state_d = (refused == MAXW) ? ARB_FORCE : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (!ll_valid_i || xfer) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else if (refused == MAXW) begin
          state_d = ARB_FORCE;
          cnt_d   = '0;
        end else begin
          cnt_d   = refused[CW-1:0];
        end
      end
      ARB_FORCE: begin
        if (!(ll_valid_i && port_busy)) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // write mux: WB first, otherwise a granted LL result to a real register
  always_comb begin
    wr_en_d = 1'b0;
    rd_d    = '0;
    data_d  = '0;
    if (port_busy) begin
      wr_en_d = 1'b1;
      rd_d    = pipe_rd_i;
      data_d  = pipe_wr_data_i;
    end else if (xfer && (ll_rd_i != '0)) begin
      wr_en_d = 1'b1;
      rd_d    = ll_rd_i;
      data_d  = ll_data_i;
    end
  end

  // FSM, hold and register-file port registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      pipe_hold_o  <= 1'b0;
      rf_wr_en_o   <= 1'b0;
      rf_rd_o      <= '0;
      rf_wr_data_o <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pipe_hold_o  <= (state_d == ARB_FORCE);
      rf_wr_en_o   <= wr_en_d;
      rf_rd_o      <= rd_d;
      rf_wr_data_o <= data_d;
    end
  end

  rf_scoreboard u_sb (
    .clk    (clk_i),
    .rst    (rst_i),
    .set_en (issue_en_i && (issue_rd_i != '0)),
    .set_rd (issue_rd_i),
    .clr_en (xfer),
    .clr_rd (ll_rd_i),
    .rs1    (id_rs1_i),
    .rs2    (id_rs2_i),
    .rd     (id_rd_i),
    .hit    (raw_stall_o)
  );

`ifdef RF_WB_PERF_CNT_EN
  // saturating count of cycles an LL result was refused
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      conflict_cnt_o <= '0;
    else if (ll_valid_i && !ll_ready_o && (conflict_cnt_o != '1))
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with MAX_WAIT=4.
// Each scenario task drives vectors and compares against hand values.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_i;
  logic        pipe_wr_en_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_wr_data_i;
  logic        ll_valid_i;
  logic [4:0]  ll_rd_i;
  logic [31:0] ll_data_i;
  logic        ll_ready_o;
  logic        issue_en_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  id_rd_i;
  logic        raw_stall_o;
  logic        pipe_hold_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wr_data_o;
`ifdef RF_WB_PERF_CNT_EN
  logic [31:0] conflict_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  rf_wb_arbiter #(.MAX_WAIT(4), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pipe_wr_en_i   (pipe_wr_en_i),
    .pipe_rd_i      (pipe_rd_i),
    .pipe_wr_data_i (pipe_wr_data_i),
    .ll_valid_i     (ll_valid_i),
    .ll_rd_i        (ll_rd_i),
    .ll_data_i      (ll_data_i),
    .ll_ready_o     (ll_ready_o),
    .issue_en_i     (issue_en_i),
    .issue_rd_i     (issue_rd_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rd_i        (id_rd_i),
    .raw_stall_o    (raw_stall_o),
    .pipe_hold_o    (pipe_hold_o),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_rd_o        (rf_rd_o),
    .rf_wr_data_o   (rf_wr_data_o)
`ifdef RF_WB_PERF_CNT_EN
    ,
    .conflict_cnt_o (conflict_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    pipe_wr_en_i = 0; pipe_rd_i = 0; pipe_wr_data_i = 0;
    ll_valid_i = 0; ll_rd_i = 0; ll_data_i = 0;
    issue_en_i = 0; issue_rd_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    tick; tick;
    rst_i = 1'b0;
    if ({rf_wr_en_o, pipe_hold_o, rf_rd_o, rf_wr_data_o} !== 39'd0) begin
      failures++;
      $display("FAIL por_outputs: got %h want 0",
               {rf_wr_en_o, pipe_hold_o, rf_rd_o, rf_wr_data_o});
    end
    checks++;
    pipe_wr_en_i = 1; pipe_rd_i = 3; pipe_wr_data_i = 32'h11;
    ll_valid_i = 1; ll_rd_i = 9; ll_data_i = 32'h99;
    issue_en_i = 1; issue_rd_i = 7;
    tick;
    issue_en_i = 0;
    tick;
    rst_i = 1'b1;
    #1;
    if ({rf_wr_en_o, pipe_hold_o, rf_rd_o, rf_wr_data_o} !== 39'd0) begin
      failures++;
      $display("FAIL reset_mid_wait: got %h want 0",
               {rf_wr_en_o, pipe_hold_o, rf_rd_o, rf_wr_data_o});
    end
    checks++;
    id_rs1_i = 7;
    #1;
    if (raw_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", raw_stall_o);
    end
    checks++;
    pipe_wr_en_i = 0; ll_valid_i = 0;
    tick;
    rst_i = 1'b0;
    id_rs1_i = 0;
    tick;
    if (rf_wr_en_o !== 1'b0 || pipe_hold_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_write: en=%b hold=%b want 0 0",
               rf_wr_en_o, pipe_hold_o);
    end
    checks++;
  endtask

  task automatic test_pipe_only;
    pipe_wr_en_i = 1; pipe_rd_i = 5; pipe_wr_data_i = 32'hDEADBEEF;
    tick;
    if ({rf_wr_en_o, rf_rd_o, rf_wr_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL pipe_write: got %b %0d %h want 1 5 deadbeef",
               rf_wr_en_o, rf_rd_o, rf_wr_data_o);
    end
    checks++;
    pipe_rd_i = 0; pipe_wr_data_i = 32'hCAFEF00D;
    tick;
    if (rf_wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL pipe_x0: got en=%b want 0", rf_wr_en_o);
    end
    checks++;
    pipe_wr_en_i = 0;
  endtask

  task automatic test_scoreboard;
    issue_en_i = 1; issue_rd_i = 7;
    tick;
    issue_en_i = 0;
    id_rs2_i = 7;
    #1;
    if (raw_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_rs2_hit: got %b want 1", raw_stall_o);
    end
    checks++;
    id_rs2_i = 0; id_rd_i = 7;
    #1;
    if (raw_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_rd_hit: got %b want 1", raw_stall_o);
    end
    checks++;
    id_rd_i = 8;
    #1;
    if (raw_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL sb_miss: got %b want 0", raw_stall_o);
    end
    checks++;
    id_rd_i = 0;
    ll_valid_i = 1; ll_rd_i = 7; ll_data_i = 32'h00000777;
    #1;
    if (ll_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_ll_ready: got %b want 1", ll_ready_o);
    end
    checks++;
    tick;
    ll_valid_i = 0;
    id_rs2_i = 7;
    #1;
    if (raw_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear: got %b want 0", raw_stall_o);
    end
    checks++;
    if ({rf_wr_en_o, rf_rd_o, rf_wr_data_o} !== {1'b1, 5'd7, 32'h777}) begin
      failures++;
      $display("FAIL sb_ll_write: got %b %0d %h want 1 7 777",
               rf_wr_en_o, rf_rd_o, rf_wr_data_o);
    end
    checks++;
    issue_en_i = 1; issue_rd_i = 7;
    tick;
    ll_valid_i = 1; ll_rd_i = 7;
    tick;
    issue_en_i = 0; ll_valid_i = 0;
    #1;
    if (raw_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_wins: got %b want 1", raw_stall_o);
    end
    checks++;
    ll_valid_i = 1;
    tick;
    ll_valid_i = 0;
    #1;
    if (raw_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL sb_final_clear: got %b want 0", raw_stall_o);
    end
    checks++;
    id_rs2_i = 0;
  endtask

  task automatic test_conflict;
    ll_valid_i = 1; ll_rd_i = 9; ll_data_i = 32'h9999AAAA;
    pipe_wr_en_i = 1; pipe_rd_i = 3;
    for (int i = 0; i < 4; i++) begin
      pipe_wr_data_i = 32'h30000000 + i;
      #1;
      if (ll_ready_o !== 1'b0 || pipe_hold_o !== 1'b0) begin
        failures++;
        $display("FAIL conflict_refuse[%0d]: ready=%b hold=%b want 0 0",
                 i, ll_ready_o, pipe_hold_o);
      end
      checks++;
      tick;
      if (rf_rd_o !== 5'd3 || rf_wr_data_o !== 32'h30000000 + i) begin
        failures++;
        $display("FAIL conflict_pipe[%0d]: got %0d %h want 3 %h",
                 i, rf_rd_o, rf_wr_data_o, 32'h30000000 + i);
      end
      checks++;
    end
    if (pipe_hold_o !== 1'b1) begin
      failures++;
      $display("FAIL conflict_hold: got %b want 1", pipe_hold_o);
    end
    checks++;
    pipe_wr_en_i = 0;
    #1;
    if (ll_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL conflict_grant: got %b want 1", ll_ready_o);
    end
    checks++;
    tick;
    ll_valid_i = 0;
    if ({rf_wr_en_o, rf_rd_o, rf_wr_data_o, pipe_hold_o} !==
        {1'b1, 5'd9, 32'h9999AAAA, 1'b0}) begin
      failures++;
      $display("FAIL conflict_ll_write: got %b %0d %h hold=%b want 1 9 9999aaaa 0",
               rf_wr_en_o, rf_rd_o, rf_wr_data_o, pipe_hold_o);
    end
    checks++;
`ifdef RF_WB_PERF_CNT_EN
    if (conflict_cnt_o !== 32'd4) begin
      failures++;
      $display("FAIL conflict_cnt: got %0d want 4", conflict_cnt_o);
    end
    checks++;
`endif
  endtask

  task automatic test_free_port;
    pipe_wr_en_i = 1; pipe_rd_i = 0; pipe_wr_data_i = 32'h0BAD0BAD;
    ll_valid_i = 1; ll_rd_i = 12; ll_data_i = 32'h12345678;
    #1;
    if (ll_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL free_ready: got %b want 1", ll_ready_o);
    end
    checks++;
    tick;
    pipe_wr_en_i = 0; ll_valid_i = 0;
    if ({rf_wr_en_o, rf_rd_o, rf_wr_data_o} !== {1'b1, 5'd12, 32'h12345678}) begin
      failures++;
      $display("FAIL free_write: got %b %0d %h want 1 12 12345678",
               rf_wr_en_o, rf_rd_o, rf_wr_data_o);
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    logic [4:0] rds [4];
    rds = '{5'd13, 5'd14, 5'd0, 5'd15};
    for (int i = 0; i < 4; i++) begin
      ll_valid_i = 1; ll_rd_i = rds[i]; ll_data_i = 32'hB0B00000 + i;
      #1;
      if (ll_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, ll_ready_o);
      end
      checks++;
      tick;
      if (rds[i] == 5'd0) begin
        if (rf_wr_en_o !== 1'b0) begin
          failures++;
          $display("FAIL b2b_x0: got en=%b want 0", rf_wr_en_o);
        end
      end else if ({rf_wr_en_o, rf_rd_o, rf_wr_data_o} !==
                   {1'b1, rds[i], 32'hB0B00000 + i}) begin
        failures++;
        $display("FAIL b2b_write[%0d]: got %b %0d %h want 1 %0d %h",
                 i, rf_wr_en_o, rf_rd_o, rf_wr_data_o, rds[i],
                 32'hB0B00000 + i);
      end
      checks++;
    end
    ll_valid_i = 0;
  endtask

  initial begin
    test_reset;
    test_pipe_only;
    test_scoreboard;
    test_conflict;
    test_free_port;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
